// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns engine over a registered 128-bit state, COLS_PER_CYCLE columns per clock.
// Latency: out_valid rises LAT = 4/COLS_PER_CYCLE cycles after the accepting edge; bypass keeps the same latency.
// Backpressure: result held in DONE until out_ready; in_ready = IDLE | (DONE & out_ready), so a new block can enter on the drain cycle.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_mode/in_bypass input handshake;
//        out_valid/out_ready/out_data output handshake; busy is high while in COMPUTE.
// Column c lives in data[127-32c -: 32], row-0 byte in the MSBs.
// Optional macro MIXCOL_INV_EN: builds the inverse datapath (in_mode=1 selects InvMixColumns).
// Without it in_mode is ignored and only the forward transform exists.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_mode,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int LAT = 4 / COLS_PER_CYCLE;
  // Column index of the first column handled in the final compute cycle.
  localparam logic [1:0] LAST_IDX = 2'((LAT - 1) * COLS_PER_CYCLE);
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t       state;
  logic [127:0] work;
  logic [127:0] work_nxt;
  logic [1:0]   col_idx;
  logic         bypass_q;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // r_i = s_i ^ (s0^s1^s2^s3) ^ 2(s_i ^ s_i+1) expands to the 2/3/1/1 matrix row.
  function automatic logic [31:0] mix_fwd(input logic [31:0] s);
    logic [7:0] s0, s1, s2, s3, t;
    s0 = s[31:24]; s1 = s[23:16]; s2 = s[15:8]; s3 = s[7:0];
    t  = s0 ^ s1 ^ s2 ^ s3;
    return {s0 ^ t ^ xtime(s0 ^ s1), s1 ^ t ^ xtime(s1 ^ s2),
            s2 ^ t ^ xtime(s2 ^ s3), s3 ^ t ^ xtime(s3 ^ s0)};
  endfunction

`ifdef MIXCOL_INV_EN
  logic mode_q;

  // InvMixColumns = MixColumns after a pre-step with u = 4(s0^s2), v = 4(s1^s3);
  // shares the forward network instead of a separate 0e/0b/0d/09 multiplier.
  function automatic logic [31:0] inv_pre(input logic [31:0] s);
    logic [7:0] u, v;
    u = xtime(xtime(s[31:24] ^ s[15:8]));
    v = xtime(xtime(s[23:16] ^ s[7:0]));
    return {s[31:24] ^ u, s[23:16] ^ v, s[15:8] ^ u, s[7:0] ^ v};
  endfunction

  function automatic logic [31:0] col_xform(input logic [31:0] s, input logic inv);
    return mix_fwd(inv ? inv_pre(s) : s);
  endfunction
`else
  // Forward-only build: the mode input stays on the interface but has no effect.
  logic unused_mode;
  assign unused_mode = in_mode;

  function automatic logic [31:0] col_xform(input logic [31:0] s);
    return mix_fwd(s);
  endfunction
`endif

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign out_data = work;
  assign busy     = (state == COMPUTE);

  // Transform the columns in the current window; bypass leaves them as-is.
  always_comb begin
    logic [1:0] rel;
    rel      = 2'd0;
    work_nxt = work;
    for (int c = 0; c < 4; c++) begin
      rel = 2'(c) - col_idx;
      if (int'(rel) < COLS_PER_CYCLE && !bypass_q) begin
`ifdef MIXCOL_INV_EN
        work_nxt[127-32*c -: 32] = col_xform(work[127-32*c -: 32], mode_q);
`else
        work_nxt[127-32*c -: 32] = col_xform(work[127-32*c -: 32]);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      col_idx   <= 2'd0;
      bypass_q  <= 1'b0;
      out_valid <= 1'b0;
`ifdef MIXCOL_INV_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) state <= COMPUTE;
        end
        COMPUTE: begin
          if (col_idx == LAST_IDX) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? COMPUTE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Mode/bypass are captured only here, so mid-block input changes are ignored.
      if (accept) begin
        work     <= in_data;
        bypass_q <= in_bypass;
        col_idx  <= 2'd0;
`ifdef MIXCOL_INV_EN
        mode_q   <= in_mode;
`endif
      end else if (state == COMPUTE) begin
        work    <= work_nxt;
        col_idx <= col_idx + STEP;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: three instances (1, 2 and 4 columns per cycle) share clock and reset.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   in_valid, in_ready, in_mode, in_bypass, out_valid, out_ready, busy;
  logic [127:0] in_data  [3];
  logic [127:0] out_data [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_mode(in_mode[0]), .in_bypass(in_bypass[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0]));

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_mode(in_mode[1]), .in_bypass(in_bypass[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1]));

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .in_mode(in_mode[2]), .in_bypass(in_bypass[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .busy(busy[2]));

  localparam logic [127:0] V_A     = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] V_A_FWD = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] V_A_FF  = 128'hcd504506_9f494f1f_01010101_5d9541ff;
  localparam logic [127:0] V_BYP   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] V_B     = 128'hc6c6c6c6_d4d4d4d5_01010101_db135345;
  localparam logic [127:0] V_B_FWD = 128'hc6c6c6c6_d5d5d7d6_01010101_8e4da1bc;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; presents a block and returns just after the accepting edge.
  task automatic send(input int d, input logic [127:0] data, input logic m, input logic b);
    in_data[d]   = data;
    in_mode[d]   = m;
    in_bypass[d] = b;
    in_valid[d]  = 1'b1;
    @(negedge clk);
    check("in_ready_at_send", 128'(in_ready[d]), 128'(1'b1));
    step();
    in_valid[d] = 1'b0;
  endtask

  // Cycles from the accepting edge to the edge where out_valid rose; -1 if it never did.
  task automatic wait_out(input int d, output int cyc);
    cyc = -1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (out_valid[d]) begin
        cyc = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cyc;
    logic [127:0] held;
    in_valid  = '0;
    in_mode   = '0;
    in_bypass = '0;
    out_ready = '1;
    for (int i = 0; i < 3; i++) in_data[i] = '0;

    // Reset state
    #12;
    check("rst_out_valid", 128'(out_valid), 128'(3'b000));
    check("rst_out_data", out_data[0], 128'h0);
    check("rst_busy", 128'(busy), 128'(3'b000));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 128'(in_ready), 128'(3'b111));

    // Forward, 1 column per cycle
    send(0, V_A, 1'b0, 1'b0);
    check("busy_compute", 128'(busy[0]), 128'(1'b1));
    wait_out(0, cyc);
    check("fwd_c1_latency", 128'(cyc), 128'(4));
    check("fwd_c1_data", out_data[0], V_A_FWD);
    step();
    check("fwd_c1_drain", 128'(out_valid[0]), 128'(1'b0));

    // Inverse request, 4 columns per cycle
    send(2, V_A_FWD, 1'b1, 1'b0);
    wait_out(2, cyc);
    check("inv_c4_latency", 128'(cyc), 128'(1));
`ifdef MIXCOL_INV_EN
    check("inv_c4_data", out_data[2], V_A);
`else
    check("inv_c4_data_fwd_only", out_data[2], V_A_FF);
`endif
    step();

    // Bypass, 2 columns per cycle
    send(1, V_BYP, 1'b0, 1'b1);
    wait_out(1, cyc);
    check("byp_c2_latency", 128'(cyc), 128'(2));
    check("byp_c2_data", out_data[1], V_BYP);
    step();

    // Backpressure then back-to-back acceptance
    out_ready[0] = 1'b0;
    send(0, V_A, 1'b0, 1'b0);
    wait_out(0, cyc);
    check("bp_latency", 128'(cyc), 128'(4));
    held = out_data[0];
    check("bp_first_data", held, V_A_FWD);
    in_data[0]  = V_B;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check("bp_hold_valid", 128'(out_valid[0]), 128'(1'b1));
      check("bp_hold_data", out_data[0], V_A_FWD);
      check("bp_in_ready_low", 128'(in_ready[0]), 128'(1'b0));
    end
    step();
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", 128'(in_ready[0]), 128'(1'b1));
    step();
    in_valid[0] = 1'b0;
    check("b2b_busy", 128'(busy[0]), 128'(1'b1));
    wait_out(0, cyc);
    check("b2b_latency", 128'(cyc), 128'(4));
    check("b2b_data", out_data[0], V_B_FWD);
    step();

    // Reset two cycles into COMPUTE
    send(0, V_A, 1'b0, 1'b0);
    step();
    step();
    check("pre_rst_busy", 128'(busy[0]), 128'(1'b1));
    rst_n = 1'b0;
    #2;
    check("mid_rst_out_valid", 128'(out_valid[0]), 128'(1'b0));
    check("mid_rst_out_data", out_data[0], 128'h0);
    check("mid_rst_busy", 128'(busy[0]), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("rel_in_ready", 128'(in_ready[0]), 128'(1'b1));
    check("rel_out_valid", 128'(out_valid[0]), 128'(1'b0));
    check("rel_out_data", out_data[0], 128'h0);
    step();
    send(0, V_B, 1'b0, 1'b0);
    wait_out(0, cyc);
    check("after_rst_latency", 128'(cyc), 128'(4));
    check("after_rst_data", out_data[0], V_B_FWD);
    step();

    // Mode toggled after acceptance must not affect the block
    send(0, V_A, 1'b0, 1'b0);
    in_mode[0] = 1'b1;
    wait_out(0, cyc);
    check("mode_toggle_latency", 128'(cyc), 128'(4));
    check("mode_toggle_data", out_data[0], V_A_FWD);
    step();
    in_mode[0] = 1'b0;

`ifdef MIXCOL_INV_EN
    send(2, V_A_FWD, 1'b1, 1'b0);
    in_mode[2] = 1'b0;
    wait_out(2, cyc);
    check("mode_toggle_inv_data", out_data[2], V_A);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
